// File: rtl/shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// shift_reg_pkg
// Shared constants for the universal shift register slice.
//   DIR_LEFT / DIR_RIGHT : encodings of the dir input
//   WIDTH_MIN / WIDTH_MAX: legal range of the WIDTH parameter
//   width_ok()           : helper telling whether a WIDTH value is legal
// ---------------------------------------------------------------------------
package shift_reg_pkg;

   localparam logic DIR_LEFT  = 1'b0;   // shift toward MSB
   localparam logic DIR_RIGHT = 1'b1;   // shift toward LSB

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 64;

   function automatic bit width_ok(input int w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

endpackage : shift_reg_pkg

// File: rtl/shift_frame_counter.sv
// ---------------------------------------------------------------------------
// shift_frame_counter
// Counts shifts within a frame of WIDTH shifts and captures the register
// contents when a frame completes.
//   clk, reset   : clock, synchronous active-high reset
//   shift        : a shift is taking effect at this edge
//   restart      : clear or load at this edge; restarts the frame count
//   next_data    : post-shift register value (captured on frame completion)
//   bit_count    : shifts since the last frame boundary (registered)
//   wrap         : this edge completes a frame (combinational)
//   frame_valid  : one-cycle pulse following the completing edge
//   frame_data   : register value captured at the last frame completion
// ---------------------------------------------------------------------------
module shift_frame_counter
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shift,
   input  logic             restart,
   input  logic [WIDTH-1:0] next_data,
   output logic [CW-1:0]    bit_count,
   output logic             wrap,
   output logic             frame_valid,
   output logic [WIDTH-1:0] frame_data
);

   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic [CW-1:0]    count_q, count_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q,  data_d;

   // restart wins over shift so a load/clear never produces a frame
   assign wrap = shift && !restart && (count_q == LAST_BIT);

   always_comb begin
      count_d = count_q;
      valid_d = wrap;
      data_d  = data_q;
      if (restart) begin
         count_d = '0;
      end else if (shift) begin
         // explicit wrap keeps non power-of-two widths correct
         count_d = wrap ? '0 : count_q + CW'(1);
      end
      if (wrap) begin
         data_d = next_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         count_q <= count_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign bit_count   = count_q;
   assign frame_valid = valid_q;
   assign frame_data  = data_q;

endmodule : shift_frame_counter

// File: rtl/universal_shift_register.sv
// ---------------------------------------------------------------------------
// universal_shift_register
// Bidirectional shift register with parallel load, synchronous clear and a
// frame counter that pulses frame_valid after every WIDTH shifts.
// Per-cycle priority: reset > clear > load > shift_enable > hold.
//   clk, reset    : clock, synchronous active-high reset
//   clear         : flush register and frame counter
//   load          : parallel load of load_data (restarts frame count)
//   shift_enable  : shift one bit this cycle
//   dir           : DIR_LEFT (toward MSB) or DIR_RIGHT (toward LSB)
//   serial_in     : bit entering the register on a shift
//   stored_data   : register contents
//   serial_out    : bit that leaves on the next shift (combinational)
//   bit_count     : shifts since last frame boundary
//   frame_valid   : one-cycle frame completion pulse
//   frame_data    : register value captured at frame completion
// ---------------------------------------------------------------------------
module universal_shift_register
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_enable,
   input  logic             dir,
   input  logic             serial_in,
   output logic [WIDTH-1:0] stored_data,
   output logic             serial_out,
   output logic [CW-1:0]    bit_count,
   output logic             frame_valid,
   output logic [WIDTH-1:0] frame_data
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             shift_go;
   logic             restart;
   logic             frame_wrap;

   assign restart  = clear || load;
   assign shift_go = shift_enable && !restart;

   always_comb begin
      data_d = data_q;
      if (clear) begin
         data_d = '0;
      end else if (load) begin
         data_d = load_data;
      end else if (shift_enable) begin
         if (dir == DIR_LEFT) begin
            data_d = {data_q[WIDTH-2:0], serial_in};
         end else begin
            data_d = {serial_in, data_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   shift_frame_counter #(.WIDTH(WIDTH)) u_frame (
      .clk         (clk),
      .reset       (reset),
      .shift       (shift_go),
      .restart     (restart),
      .next_data   (data_d),
      .bit_count   (bit_count),
      .wrap        (frame_wrap),
      .frame_valid (frame_valid),
      .frame_data  (frame_data)
   );

   // frame_wrap is consumed inside the counter; kept visible for checkers
   logic frame_wrap_unused;
   assign frame_wrap_unused = frame_wrap;

   assign stored_data = data_q;
   assign serial_out  = (dir == DIR_LEFT) ? data_q[WIDTH-1] : data_q[0];

endmodule : universal_shift_register

// File: tb/tb_universal_shift_register.sv
// ---------------------------------------------------------------------------
// tb_universal_shift_register
// Directed and randomized checks of universal_shift_register (WIDTH=8)
// against a behavioural model built from plain arithmetic.
// Handshake note: there is no valid/ready flow; every input is applied one
// time unit after a rising edge and outputs are sampled one time unit after
// the following rising edge.
// ---------------------------------------------------------------------------
module tb_universal_shift_register;

   localparam int W  = 8;
   localparam int CW = $clog2(W);

   // ---------------- clock / reset block ----------------
   logic clk;
   logic reset, clear, load, shift_enable, dir, serial_in;
   logic [W-1:0]  load_data;
   logic [W-1:0]  stored_data, frame_data;
   logic          serial_out, frame_valid;
   logic [CW-1:0] bit_count;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   universal_shift_register #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .load         (load),
      .load_data    (load_data),
      .shift_enable (shift_enable),
      .dir          (dir),
      .serial_in    (serial_in),
      .stored_data  (stored_data),
      .serial_out   (serial_out),
      .bit_count    (bit_count),
      .frame_valid  (frame_valid),
      .frame_data   (frame_data)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model + scoreboard ----------------
   logic [W-1:0] m_reg;
   logic [W-1:0] m_fd;
   int           m_cnt;
   logic         m_fv;
   logic [W-1:0] exp_q[$];

   // Drive one cycle of inputs and advance the model to the post-edge state.
   task automatic cycle(input logic rst, input logic clr, input logic ld,
                        input logic [W-1:0] ld_d, input logic sh,
                        input logic d, input logic si);
      reset = rst; clear = clr; load = ld; load_data = ld_d;
      shift_enable = sh; dir = d; serial_in = si;
      if (rst) begin
         m_reg = '0; m_cnt = 0; m_fv = 1'b0; m_fd = '0;
      end else if (clr) begin
         m_reg = '0; m_cnt = 0; m_fv = 1'b0;
      end else if (ld) begin
         m_reg = ld_d; m_cnt = 0; m_fv = 1'b0;
      end else if (sh) begin
         if (d == 1'b0) m_reg = W'((int'(m_reg) * 2 + int'(si)) % 256);
         else           m_reg = W'(int'(m_reg) / 2 + int'(si) * 128);
         m_cnt = m_cnt + 1;
         if (m_cnt == W) begin
            m_cnt = 0; m_fv = 1'b1; m_fd = m_reg;
            exp_q.push_back(m_reg);
         end else begin
            m_fv = 1'b0;
         end
      end else begin
         m_fv = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, dir, 1'b0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
      checks++;
      if (stored_data !== 8'h00 || bit_count !== 3'd0 || frame_valid !== 1'b0 ||
          frame_data !== 8'h00 || serial_out !== 1'b0) begin
         errors++;
         $display("FAIL reset: data=%h cnt=%0d fv=%b fd=%h so=%b required all 0",
                  stored_data, bit_count, frame_valid, frame_data, serial_out);
      end
   endtask

   task automatic test_left_frame();
      logic [7:0] bits;
      int pulses;
      bits = 8'b1011_0010;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, bits[7-i]);
         if (frame_valid) pulses++;
         checks++;
         if (bit_count !== CW'(m_cnt)) begin
            errors++;
            $display("FAIL left_count[%0d]: got %0d required %0d", i, bit_count, m_cnt);
         end
      end
      checks++;
      if (stored_data !== 8'hB2 || frame_data !== 8'hB2 || frame_valid !== 1'b1) begin
         errors++;
         $display("FAIL left_frame: data=%h fd=%h fv=%b required B2 B2 1",
                  stored_data, frame_data, frame_valid);
      end
      idle();
      checks++;
      if (frame_valid !== 1'b0 || pulses != 1 || frame_data !== 8'hB2) begin
         errors++;
         $display("FAIL left_pulse_once: fv=%b pulses=%0d fd=%h required 0 1 B2",
                  frame_valid, pulses, frame_data);
      end
   endtask

   task automatic test_right_frame();
      logic [7:0] so_seq;
      int pulses;
      so_seq = 8'b1010_0101;
      pulses = 0;
      cycle(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (serial_out !== so_seq[7-i]) begin
            errors++;
            $display("FAIL right_serial_out[%0d]: got %b required %b", i, serial_out, so_seq[7-i]);
         end
         cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
         if (frame_valid) pulses++;
      end
      checks++;
      if (stored_data !== 8'h00 || frame_data !== 8'h00 || pulses != 1 || bit_count !== 3'd0) begin
         errors++;
         $display("FAIL right_frame: data=%h fd=%h pulses=%0d cnt=%0d required 00 00 1 0",
                  stored_data, frame_data, pulses, bit_count);
      end
   endtask

   task automatic test_priority();
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
      checks++;
      if (stored_data !== 8'h3C || bit_count !== 3'd0 || frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL load_over_shift: data=%h cnt=%0d fv=%b required 3C 0 0",
                  stored_data, bit_count, frame_valid);
      end
      cycle(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
      checks++;
      if (stored_data !== 8'h00 || bit_count !== 3'd0) begin
         errors++;
         $display("FAIL clear_over_load: data=%h cnt=%0d required 00 0", stored_data, bit_count);
      end
   endtask

   task automatic test_clear_midframe();
      int pulses;
      logic [W-1:0] fd_before;
      pulses = 0;
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      fd_before = m_fd;
      cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bit_count !== 3'd0 || frame_valid !== 1'b0 || stored_data !== 8'h00 || frame_data !== fd_before) begin
         errors++;
         $display("FAIL clear_midframe: cnt=%0d fv=%b data=%h fd=%h required 0 0 00 %h",
                  bit_count, frame_valid, stored_data, frame_data, fd_before);
      end
      for (int i = 0; i < 7; i++) begin
         cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
         if (frame_valid) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL clear_early_frame: got %0d pulses required 0", pulses);
      end
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (frame_valid !== 1'b1 || frame_data !== m_fd) begin
         errors++;
         $display("FAIL clear_8th_shift: fv=%b fd=%h required 1 %h", frame_valid, frame_data, m_fd);
      end
   endtask

   task automatic test_reset_midframe();
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
      checks++;
      if (stored_data !== 8'h00 || bit_count !== 3'd0 || frame_valid !== 1'b0 ||
          frame_data !== 8'h00 || serial_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_midframe: data=%h cnt=%0d fv=%b fd=%h so=%b required all 0",
                  stored_data, bit_count, frame_valid, frame_data, serial_out);
      end
      idle();
      checks++;
      if (frame_valid !== 1'b0 || frame_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_no_frame: fv=%b fd=%h required 0 00", frame_valid, frame_data);
      end
   endtask

   task automatic test_mixed_dir();
      logic [CW-1:0] held;
      cycle(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, (i >= 4), 1'($urandom_range(0, 1)));
         checks++;
         if (frame_valid !== ((i == 7) ? 1'b1 : 1'b0) || stored_data !== m_reg) begin
            errors++;
            $display("FAIL mixed_shift[%0d]: fv=%b data=%h required %b %h",
                     i, frame_valid, stored_data, (i == 7), m_reg);
         end
         held = bit_count;
         idle();
         idle();
         checks++;
         if (bit_count !== held || bit_count !== CW'(m_cnt) || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL mixed_idle[%0d]: cnt=%0d fv=%b required %0d 0", i, bit_count, frame_valid, m_cnt);
         end
      end
      checks++;
      if (frame_data !== m_fd) begin
         errors++;
         $display("FAIL mixed_frame_data: got %h required %h", frame_data, m_fd);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] exp_fd;
      logic         exp_so;
      exp_q.delete();
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 4),
               ($urandom_range(0, 99) < 6), W'($urandom_range(0, 255)),
               ($urandom_range(0, 99) < 75), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
         exp_so = dir ? m_reg[0] : m_reg[W-1];
         checks++;
         if (stored_data !== m_reg || bit_count !== CW'(m_cnt) || frame_valid !== m_fv ||
             frame_data !== m_fd || serial_out !== exp_so) begin
            errors++;
            $display("FAIL random[%0d]: data=%h cnt=%0d fv=%b fd=%h so=%b required %h %0d %b %h %b",
                     i, stored_data, bit_count, frame_valid, frame_data, serial_out,
                     m_reg, m_cnt, m_fv, m_fd, exp_so);
         end
         if (frame_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL random_frame_unexpected[%0d]: fd=%h required no frame", i, frame_data);
            end else begin
               exp_fd = exp_q.pop_front();
               if (frame_data !== exp_fd) begin
                  errors++;
                  $display("FAIL random_frame_data[%0d]: got %h required %h", i, frame_data, exp_fd);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL random_frames_missing: %0d frames never seen required 0", exp_q.size());
      end
   endtask

   // ---------------- sequence + final report ----------------
   initial begin
      reset = 1'b0; clear = 1'b0; load = 1'b0; load_data = '0;
      shift_enable = 1'b0; dir = 1'b0; serial_in = 1'b0;
      m_reg = '0; m_fd = '0; m_cnt = 0; m_fv = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_left_frame();
      test_right_frame();
      test_priority();
      test_clear_midframe();
      test_reset_midframe();
      test_mixed_dir();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_universal_shift_register
